// File: rtl/uart_rx_fifo_8n1.sv
// rtl/uart_rx_fifo_8n1.sv - oversampling 8N1 UART receiver feeding a show-ahead byte FIFO
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
`timescale 1ns/1ps
module uart_rx_fifo_8n1 #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          RX_LINE,
    input  logic                          RD,
    output logic [7:0]                    DATA_OUT,
    output logic                          RX_VALID,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          FRAME_ERR,
    output logic                          PARITY_ERR,
    output logic                          OVERRUN
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [31:0]   INC  = 32'(BAUD * OVERSAMPLE);
    localparam logic [31:0]   CLKF = 32'(CLK_FREQ);
    localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

    logic [1:0]    sync_q;
    logic          rx_s;
    logic [31:0]   acc_q, acc_d, acc_sum;
    logic          tick_q, tick_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          stop_sample, par_bad, push_now, ferr_now, perr_now;
    logic          push_q, frame_err_q, parity_err_q;
    logic [7:0]    push_data_q;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign rx_s = sync_q[1];

    assign acc_sum = acc_q + INC;
    always_comb begin
        tick_d = (acc_sum >= CLKF);
        acc_d  = tick_d ? acc_sum - CLKF : acc_sum;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q  <= 2'b11;
            acc_q   <= '0;
            tick_q  <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], RX_LINE};
            acc_q   <= acc_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // START waits half a bit so every later sample lands on a bit centre.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (tick_q) begin
                    if (cnt_q == MID) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick_q) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tick_q) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_STOP;
`ifdef UART_RX_PARITY_EN
                        par_d   = rx_s;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (tick_q) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = rx_s ? S_IDLE : S_WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stop_sample = (state_q == S_STOP) && tick_q && (cnt_q == LAST);
`ifdef UART_RX_PARITY_EN
        par_bad     = (par_q != ^shift_q);
`else
        par_bad     = 1'b0;
`endif
        push_now    = stop_sample && rx_s && !par_bad;
        ferr_now    = stop_sample && !rx_s;
        perr_now    = stop_sample && par_bad;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            push_q       <= 1'b0;
            push_data_q  <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            push_q       <= push_now;
            push_data_q  <= shift_q;
            frame_err_q  <= ferr_now;
            parity_err_q <= perr_now;
        end
    end

    assign FRAME_ERR = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR = parity_err_q;
`else
    assign PARITY_ERR = 1'b0;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic [7:0]    hold_q;
    logic          overrun_q;
    logic          do_pop, do_push;

    assign do_pop  = RD && (level_q != '0);
    assign do_push = push_q && ((level_q != FULL) || do_pop);

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr_q] <= push_data_q;
    end

    // hold_q keeps the last shown head so DATA_OUT is stable once the FIFO drains.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            hold_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
            if (RX_VALID) hold_q <= mem[rd_ptr_q];
            if (push_q && !do_push) overrun_q <= 1'b1;
        end
    end

    assign RX_VALID   = (level_q != '0);
    assign DATA_OUT   = RX_VALID ? mem[rd_ptr_q] : hold_q;
    assign FIFO_LEVEL = level_q;
    assign OVERRUN    = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo_8n1.sv
// tb/tb_uart_rx_fifo_8n1.sv - randomized scoreboard bench for uart_rx_fifo_8n1
`timescale 1ns/1ps
module tb_uart_rx_fifo_8n1;
    localparam int CPB   = 217;
    localparam int DEPTH = 16;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       RX_LINE = 1'b1;
    logic       RD = 1'b0;
    logic [7:0] DATA_OUT;
    logic       RX_VALID;
    logic [4:0] FIFO_LEVEL;
    logic       FRAME_ERR;
    logic       PARITY_ERR;
    logic       OVERRUN;

    uart_rx_fifo_8n1 dut (
        .CLK(CLK), .RESET_N(RESET_N), .RX_LINE(RX_LINE), .RD(RD),
        .DATA_OUT(DATA_OUT), .RX_VALID(RX_VALID), .FIFO_LEVEL(FIFO_LEVEL),
        .FRAME_ERR(FRAME_ERR), .PARITY_ERR(PARITY_ERR), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    bit         exp_ovr = 1'b0;
    bit         rd_en = 1'b0;
    bit         valid_seen = 1'b0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         exp_ferr = 0;
    int         exp_perr = 0;
    logic [7:0] last_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops whenever the DUT presents a byte and reading is enabled.
    initial begin
        forever begin
            @(negedge CLK);
            if (FRAME_ERR) ferr_cnt++;
            if (PARITY_ERR) perr_cnt++;
            if (RX_VALID) valid_seen = 1'b1;
            if (rd_en && RX_VALID && RESET_N) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", DATA_OUT);
                end else begin
                    check("rx_byte", {24'h0, DATA_OUT}, {24'h0, exp_q.pop_front()});
                end
                last_byte = DATA_OUT;
                RD = 1'b1;
            end else begin
                RD = 1'b0;
            end
        end
    end

    task automatic drive(input logic v, input int n);
        RX_LINE = v;
        repeat (n) @(negedge CLK);
    endtask

    // Reference model: a good frame enters the FIFO unless it already holds DEPTH bytes.
    task automatic send_frame(input logic [7:0] d, input int cpb, input bit stop, input bit bad_par);
        if (stop && !bad_par) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else exp_ovr = 1'b1;
        end
        if (!stop) exp_ferr++;
        if (bad_par) exp_perr++;
        drive(1'b0, cpb);
        for (int i = 0; i < 8; i++) drive(d[i], cpb);
`ifdef UART_RX_PARITY_EN
        drive((^d) ^ bad_par, cpb);
`endif
        drive(stop, cpb);
        RX_LINE = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) check({name, "_drain_timeout"}, exp_q.size(), 0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        logic [7:0] rd;
        int         rc;
        int         f0;

        RESET_N = 1'b0;
        repeat (5) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("rst_data_out", DATA_OUT, 8'h00);
        check("rst_rx_valid", RX_VALID, 1'b0);
        check("rst_level", FIFO_LEVEL, 0);
        check("rst_frame_err", FRAME_ERR, 1'b0);
        check("rst_overrun", OVERRUN, 1'b0);
        valid_seen = 1'b0;
        repeat (10000) @(negedge CLK);
        check("idle_no_valid", valid_seen, 1'b0);

        rd_en = 1'b0;
        send_frame(8'h41, CPB, 1'b1, 1'b0);
        check("first_valid_by_stop_end", RX_VALID, 1'b1);
        check("first_data", DATA_OUT, exp_q[0]);
        check("first_level", FIFO_LEVEL, exp_q.size());
        rd_en = 1'b1;
        wait_drain("first");
        check("pop_valid", RX_VALID, 1'b0);
        check("pop_level", FIFO_LEVEL, 0);
        check("hold_after_empty", DATA_OUT, 8'h41);
        drive(1'b1, CPB);

        f0 = ferr_cnt;
        drive(1'b0, 40);
        drive(1'b1, 2 * CPB);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check("glitch_no_push", FIFO_LEVEL, 0);
        send_frame(8'h7E, CPB, 1'b1, 1'b0);
        drive(1'b1, CPB);
        wait_drain("after_glitch");

        f0 = ferr_cnt;
        send_frame(8'h55, CPB, 1'b0, 1'b0);
        drive(1'b1, 2 * CPB);
        check("bad_stop_one_ferr", ferr_cnt - f0, 1);
        check("bad_stop_level", FIFO_LEVEL, 0);
        send_frame(8'h33, CPB, 1'b1, 1'b0);
        drive(1'b1, CPB);
        wait_drain("after_ferr");

        rd_en = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), CPB, 1'b1, 1'b0);
            drive(1'b1, CPB);
        end
        check("full_level", FIFO_LEVEL, exp_q.size());
        check("overrun_set", OVERRUN, exp_ovr);
        rd_en = 1'b1;
        wait_drain("full");
        check("full_drained_valid", RX_VALID, 1'b0);
        check("full_hold_last", DATA_OUT, last_byte);

        send_frame(8'hA5, 213, 1'b1, 1'b0);
        drive(1'b1, CPB);
        wait_drain("fast_baud");
        send_frame(8'hA5, 221, 1'b1, 1'b0);
        drive(1'b1, CPB);
        wait_drain("slow_baud");

`ifdef UART_RX_PARITY_EN
        send_frame(8'hA5, CPB, 1'b1, 1'b1);
        drive(1'b1, CPB);
        check("bad_parity_no_push", FIFO_LEVEL, 0);
`endif

        for (int k = 0; k < 3; k++) begin
            rd = 8'($urandom_range(0, 255));
            rc = int'($urandom_range(213, 221));
            send_frame(rd, rc, 1'b1, 1'b0);
            drive(1'b1, CPB);
            wait_drain("random");
        end

        check("overrun_sticky", OVERRUN, exp_ovr);
        check("frame_err_total", ferr_cnt, exp_ferr);
        check("parity_err_total", perr_cnt, exp_perr);
        check("final_level", FIFO_LEVEL, exp_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
